// File: rtl/bin2ternary_serial_pkg.sv
// ============================================================================
// Module      : bin2ternary_serial_pkg
// Description : Shared ternary types, trit encoding and binary/ternary helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bin2ternary_serial_pkg;

    // Two-bit trit encoding shared by the whole ternary datapath.
    typedef enum logic [1:0] {
        T_ZERO    = 2'b00,
        T_POS_ONE = 2'b01,
        T_NEG_ONE = 2'b10,
        T_INVALID = 2'b11
    } trit_t;

    // Trit words are ordered trit 0 = least significant (index 0 is 3^0).
    typedef trit_t [26:0] trit27_t;

    localparam trit27_t TRIT27_ZERO = {27{T_ZERO}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } b2t_state_t;

    function automatic trit_t t_from_rem(input int rem);
        case (rem)
            -1:      return T_NEG_ONE;
            1:       return T_POS_ONE;
            default: return T_ZERO;
        endcase
    endfunction

    function automatic longint ternary_to_bin(input trit27_t t);
        longint acc;
        acc = 0;
        for (int i = 26; i >= 0; i--) begin
            acc = acc * 3;
            if (t[i] == T_POS_ONE)      acc = acc + 1;
            else if (t[i] == T_NEG_ONE) acc = acc - 1;
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2ternary_serial_divmod3.sv
// ============================================================================
// Module      : b2t_divmod3
// Description : Combinational balanced division by 3: temp = 3*q + r, r in {-1,0,+1}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module b2t_divmod3
    import bin2ternary_serial_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic signed [DATA_W-1:0] temp,
    output logic signed [DATA_W-1:0] q,
    output trit_t                    r
);

    localparam logic signed [DATA_W-1:0] c_one   = DATA_W'(1);
    localparam logic signed [DATA_W-1:0] c_two   = DATA_W'(2);
    localparam logic signed [DATA_W-1:0] c_three = DATA_W'(3);

    logic signed [DATA_W-1:0] w_q_trunc;
    logic signed [DATA_W-1:0] w_r_trunc;
    int                       w_rem;

    // Truncating division leaves a remainder in [-2,2]; fold +/-2 into the
    // balanced digit by moving one unit into the quotient.
    always_comb begin
        w_q_trunc = temp / c_three;
        w_r_trunc = temp - (w_q_trunc * c_three);
        q         = w_q_trunc;
        w_rem     = 0;
        if (w_r_trunc == c_two) begin
            w_rem = -1;
            q     = w_q_trunc + c_one;
        end else if (w_r_trunc == -c_two) begin
            w_rem = 1;
            q     = w_q_trunc - c_one;
        end else if (w_r_trunc == c_one) begin
            w_rem = 1;
        end else if (w_r_trunc == -c_one) begin
            w_rem = -1;
        end
        r = t_from_rem(w_rem);
    end

endmodule

`default_nettype wire

// File: rtl/bin2ternary_serial.sv
// ============================================================================
// Module      : bin2ternary_serial
// Description : Serial signed-binary to balanced-ternary converter, one trit
//               per clock. Define B2T_EARLY_EXIT_EN to stop once temp hits 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2ternary_serial
    import bin2ternary_serial_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int N_TRITS = 27
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*N_TRITS-1:0]    out_trits,
    output logic                    out_ovf,
    output logic                    busy
);

    localparam int                CNT_W      = $clog2(N_TRITS + 1);
    localparam logic [CNT_W-1:0]  c_last_cnt = CNT_W'(N_TRITS - 1);

    b2t_state_t                r_state;
    b2t_state_t                w_state_next;
    logic signed [DATA_W-1:0]  r_temp;
    logic [CNT_W-1:0]          r_cnt;
    logic [2*N_TRITS-1:0]      r_trits;
    logic                      r_ovf;
    logic signed [DATA_W-1:0]  w_q;
    trit_t                     w_r;
    logic                      w_last;
    logic                      w_skip;

    b2t_divmod3 #(.DATA_W(DATA_W)) u_divmod3 (
        .temp (r_temp),
        .q    (w_q),
        .r    (w_r)
    );

    always_comb begin
        w_last = (r_cnt == c_last_cnt);
`ifdef B2T_EARLY_EXIT_EN
        w_skip = (r_temp == '0);
`else
        w_skip = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = CONV;
            end
            CONV: begin
                busy = 1'b1;
                if (w_skip || w_last) w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_temp  <= '0;
            r_cnt   <= '0;
            r_trits <= {N_TRITS{T_ZERO}};
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_temp  <= in_data;
                        r_cnt   <= '0;
                        r_trits <= {N_TRITS{T_ZERO}};
                        r_ovf   <= 1'b0;
                    end
                end
                CONV: begin
                    if (!w_skip) begin
                        for (int i = 0; i < N_TRITS; i++) begin
                            if (r_cnt == CNT_W'(i)) r_trits[2*i +: 2] <= w_r;
                        end
                        r_temp <= w_q;
                        // cnt parks on the last index instead of stepping past it
                        if (w_last) r_ovf <= (w_q != '0);
                        else        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_trits = r_trits;
    assign out_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bin2ternary_serial.sv
// ============================================================================
// Module      : tb_bin2ternary_serial
// Description : Self-checking bench: 27-trit and 3-trit converters against an
//               arithmetic balanced-ternary model. Honours B2T_EARLY_EXIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2ternary_serial;
    import bin2ternary_serial_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               in_valid_l, in_ready_l, out_valid_l, out_ready_l, out_ovf_l, busy_l;
    logic signed [31:0] in_data_l;
    logic [53:0]        out_trits_l;
    logic               in_valid_s, in_ready_s, out_valid_s, out_ready_s, out_ovf_s, busy_s;
    logic signed [31:0] in_data_s;
    logic [5:0]         out_trits_s;

    int vectors;
    int miscompares;

    bin2ternary_serial #(.DATA_W(32), .N_TRITS(27)) u_dut_l (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_l), .in_ready(in_ready_l), .in_data(in_data_l),
        .out_valid(out_valid_l), .out_ready(out_ready_l),
        .out_trits(out_trits_l), .out_ovf(out_ovf_l), .busy(busy_l)
    );

    bin2ternary_serial #(.DATA_W(32), .N_TRITS(3)) u_dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .out_trits(out_trits_s), .out_ovf(out_ovf_s), .busy(busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Balanced ternary by plain integer arithmetic: pick digit d in {-1,0,1}
    // with x = d (mod 3), then divide the rest exactly.
    function automatic void ref_model(input longint v, input int n, output logic [63:0] t,
                                      output logic ovf, output int steps);
        longint x;
        longint d;
        x     = v;
        t     = '0;
        steps = 0;
        for (int i = 0; i < n; i++) begin
            if (x != 0) steps = i + 1;
            d = ((x % 3) + 3) % 3;
            if (d == 2) d = -1;
            t[2*i +: 2] = (d == 1) ? T_POS_ONE : (d == -1) ? T_NEG_ONE : T_ZERO;
            x = (x - d) / 3;
        end
        ovf = (x != 0);
    endfunction

    function automatic logic get_ready(input bit s);  return s ? in_ready_s  : in_ready_l;  endfunction
    function automatic logic get_valid(input bit s);  return s ? out_valid_s : out_valid_l; endfunction
    function automatic logic get_busy(input bit s);   return s ? busy_s      : busy_l;      endfunction
    function automatic logic get_ovf(input bit s);    return s ? out_ovf_s   : out_ovf_l;   endfunction
    function automatic logic [63:0] get_trits(input bit s);
        return s ? 64'(out_trits_s) : 64'(out_trits_l);
    endfunction

    task automatic set_ready(input bit s, input logic v);
        if (s) out_ready_s = v;
        else   out_ready_l = v;
    endtask

    task automatic convert(input bit s, input logic signed [31:0] v, input int hold);
        int          n;
        int          steps;
        int          lat;
        int          cyc;
        logic [63:0] exp_t;
        logic        exp_o;
        n = s ? 3 : 27;
        ref_model(longint'(v), n, exp_t, exp_o, steps);
`ifdef B2T_EARLY_EXIT_EN
        lat = (steps < n) ? steps + 1 : n;
`else
        lat = n;
`endif
        check("idle_in_ready", 64'(get_ready(s)), 64'd1);
        if (s) begin in_valid_s = 1'b1; in_data_s = v; end
        else   begin in_valid_l = 1'b1; in_data_l = v; end
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        in_valid_l = 1'b0;
        check("conv_busy", 64'(get_busy(s)), 64'd1);
        check("conv_in_ready", 64'(get_ready(s)), 64'd0);
        cyc = 0;
        while (!get_valid(s) && cyc < n + 5) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("out_valid_seen", 64'(get_valid(s)), 64'd1);
        check("latency", 64'(cyc), 64'(lat));
        check("trits", get_trits(s), exp_t);
        check("ovf", 64'(get_ovf(s)), 64'(exp_o));
        if (!s) check("roundtrip", 64'(ternary_to_bin(trit27_t'(out_trits_l))), 64'(longint'(v)));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_trits", get_trits(s), exp_t);
            check("hold_in_ready", 64'(get_ready(s)), 64'd0);
            check("hold_valid", 64'(get_valid(s)), 64'd1);
        end
        set_ready(s, 1'b1);
        @(posedge clk); #1;
        set_ready(s, 1'b0);
        check("release_valid", 64'(get_valid(s)), 64'd0);
        check("release_in_ready", 64'(get_ready(s)), 64'd1);
    endtask

    initial begin
        logic signed [31:0] rv;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid_l  = 1'b0; in_data_l = '0; out_ready_l = 1'b0;
        in_valid_s  = 1'b0; in_data_s = '0; out_ready_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready_l), 64'd1);
        check("rst_out_valid", 64'(out_valid_l), 64'd0);
        check("rst_busy", 64'(busy_l), 64'd0);
        check("rst_ovf", 64'(out_ovf_l), 64'd0);
        check("rst_trits", 64'(out_trits_l), 64'd0);
        check("rst_trits_s", 64'(out_trits_s), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        convert(1'b0, 32'sd5, 0);
        convert(1'b0, 32'sd0, 0);
        convert(1'b0, -32'sd1, 0);
        convert(1'b0, 32'h8000_0000, 0);
        convert(1'b0, 32'h7FFF_FFFF, 0);
        convert(1'b0, 32'sd42, 10);

        convert(1'b1, 32'sd14, 0);
        convert(1'b1, 32'sd13, 0);
        convert(1'b1, -32'sd13, 0);
        convert(1'b1, -32'sd14, 0);

        // Abort a conversion part-way through with an asynchronous reset.
        in_valid_l = 1'b1;
        in_data_l  = 32'sd2000000000;
        @(posedge clk); #1;
        in_valid_l = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy_l), 64'd0);
        check("abort_in_ready", 64'(in_ready_l), 64'd1);
        check("abort_out_valid", 64'(out_valid_l), 64'd0);
        check("abort_trits", 64'(out_trits_l), 64'd0);
        check("abort_ovf", 64'(out_ovf_l), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        convert(1'b0, 32'sd100, 0);

        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) rv = $signed($urandom);
            else            rv = $signed(32'($urandom_range(0, 2000))) - 32'sd1000;
            convert(1'b0, rv, int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 12; i++) begin
            rv = $signed(32'($urandom_range(0, 40))) - 32'sd20;
            convert(1'b1, rv, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bin2ternary_serial.md
# bin2ternary_serial

Sequential binary-to-balanced-ternary converter at the boundary between the binary host/load path and the ternary datapath. Accepts one signed binary word per valid/ready transaction and produces one trit per clock by repeated balanced division by 3, emitting an N-trit word in the shared 2-bit trit encoding. The output feeds the register-file write port and immediate loaders, which consume `trit27_t` words.

## Interface
- `DATA_W`, 32: width of signed binary input.
- `N_TRITS`, 27: number of output trits; 27 matches `trit27_t`.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  converter can accept a word.
- `in_data`  in  DATA_W  signed two's-complement value.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_trits`  out  2*N_TRITS  `trit_t [N_TRITS-1:0]`; trit 0 is least significant.
- `out_ovf`  out  1  value not representable in N_TRITS trits.
- `busy`  out  1  high in CONV.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`:
  - load `temp <= in_data`;
  - clear `out_trits` to all T_ZERO;
  - `cnt <= 0`, `out_ovf <= 0`;
  - go to CONV.
- CONV, per cycle:
  - Compute `q`, `r` with `temp = 3*q + r`, `r` in {-1, 0, +1}. This must be correct for negative `temp`: take the truncating quotient and remainder, then correct by ±1.
  - Write `trit[cnt] <= r` (-1→T_NEG_ONE, 0→T_ZERO, +1→T_POS_ONE). Then `temp <= q`, `cnt++`.
  - After writing `cnt == N_TRITS-1`, go to DONE. In that cycle, `out_ovf <= (q != 0)`.
- DONE: `out_valid`=1. `out_trits` and `out_ovf` are held stable while `out_ready` is low. On `out_ready`, go to IDLE.
- `temp` is DATA_W signed; the magnitude is non-increasing, so no widening is needed. The most negative input is handled (r=+1).
- T_INVALID is never produced.
- No overlap: a new input is accepted only in IDLE. `in_ready` is low in CONV and DONE.
- `cnt` is `$clog2(N_TRITS+1)` bits and never wraps past N_TRITS-1.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`=1, `out_valid`=0, `busy`=0, `out_ovf`=0;
  - `out_trits` all T_ZERO;
  - `cnt`=0, `temp`=0.
- Without early exit: `out_valid` rises exactly N_TRITS cycles after the accepting edge.
- The result is visible in the same cycle `out_valid` rises.
- DONE→IDLE occurs on the edge where `out_ready`=1. `in_ready` is high in the following cycle, which gives a minimum initiation interval of N_TRITS+2.
- Reset asserted mid-CONV or in DONE aborts immediately to the reset values. No partial result is presented.
- `in_valid` while not ready is ignored; the upstream must hold the word.

## Configuration
- `B2T_EARLY_EXIT_EN` defined:
  - In CONV, if `temp == 0` at the start of a cycle, go to DONE without writing. Remaining trits are already zero.
  - `out_ovf` = 0 in that case.
  - Latency becomes (significant trits + 1), minimum 1 (input 0).
- Undefined: fixed N_TRITS-cycle latency regardless of value.

## Structure
- Shared ternary package additions:
  - `b2t_state_t` enum (IDLE/CONV/DONE);
  - function `t_from_rem(int)` → `trit_t`;
  - comment stating the trit-0-LSB ordering.
- Reuse `trit_t`, `trit27_t`, `TRIT27_ZERO` from the package.
- One sub-module: `b2t_divmod3`, combinational, DATA_W-parameterized. Input `temp`; outputs `q` and 2-bit `r` as `trit_t`. It is unit-testable on its own.

## Test plan
- `in_data`=5, macro off → after 27 cycles: `out_valid`; t0=-1, t1=-1, t2=+1, rest 0; `out_ovf`=0.
- `in_data`=5 with `B2T_EARLY_EXIT_EN` → `out_valid` 4 cycles after accept, same trits. `in_data`=0 → 1 cycle, all zero.
- `in_data`=-1, then -2147483648, then 2147483647 → round-trip via the package `ternary_to_bin` equals input; `out_ovf`=0.
- N_TRITS=3 instance, `in_data`=14 → trits -1,-1,-1; `out_ovf`=1. `in_data`=13 → +1,+1,+1; `out_ovf`=0.
- Hold `out_ready`=0 for 10 cycles in DONE → `out_trits` stable, `in_ready`=0. Release → IDLE next cycle and next word accepted.
- Drop `rst_n` at CONV cycle 10 → outputs immediately at reset values. After release, a fresh conversion of 100 gives the correct result (100 = 81+27-9+1: t0=+1, t1=0, t2=-1, t3=+1, t4=+1).
